adsr_env: RTL and testbench
===========================

ADSR_ENV -- requirements
Module: adsr_env

Interface
REQ-001 WIDTH, default 8: width of the rate, sustain and cv ports; the level register is 2*WIDTH bits wide.
REQ-002 PRESCALE, default 256: clocks per envelope tick, legal range 1..65535.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1: reset, synchronous and active-low.
REQ-005 gate  input  1: note gate; high = key held.
REQ-006 attack  input  WIDTH: attack rate code; larger = faster.
REQ-007 decay  input  WIDTH: decay rate code; larger = faster.
REQ-008 sustain  input  WIDTH: sustain level, unsigned, 0..2^WIDTH-1.
REQ-009 release  input  WIDTH: release rate code; larger = faster.
REQ-010 cv  output  WIDTH: envelope level, unsigned, directly drives the svca cv input.
REQ-011 active  output  1: high whenever state != IDLE.

Function
REQ-012 States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE; held in a registered state variable.
REQ-013 Level register lvl: 2*WIDTH bits, unsigned; cv = lvl[2*WIDTH-1:WIDTH], registered, no combinational path from inputs.
REQ-014 Tick: free-running prescaler asserts a one-cycle tick when its count reaches PRESCALE-1, then wraps to 0; PRESCALE=1 gives tick every cycle.
REQ-015 Step per tick = rate code + 1, zero-extended to 2*WIDTH bits (for WIDTH=8: full scale in 256..65536 ticks).
REQ-016 Gate edges: gate registered once; a rise (prev 0, now 1) or fall (prev 1, now 0) is acted on in the same cycle it is detected, without waiting for tick.
REQ-017 Gate rise from IDLE, DECAY, SUSTAIN or RELEASE -> ATTACK; lvl is kept (no retrigger to zero).
REQ-018 Gate fall from ATTACK, DECAY or SUSTAIN -> RELEASE, lvl kept.
REQ-019 A gate edge and a tick in the same cycle: the edge transition wins, lvl is unchanged that cycle.
REQ-020 ATTACK on tick: lvl += step_a, saturating at all-ones; on reaching all-ones -> DECAY.
REQ-021 DECAY: target = {sustain, WIDTH zeros}; on tick, if lvl - step_d <= target or lvl <= target, then lvl = target and state -> SUSTAIN, else lvl -= step_d.
REQ-022 SUSTAIN: lvl = target every cycle; live sustain changes are followed immediately.
REQ-023 RELEASE on tick: lvl -= step_r, floor 0; a tick at lvl = 0 -> IDLE.
REQ-024 IDLE: lvl holds 0; ticks have no effect.
REQ-025 Rate and sustain inputs are sampled on the cycle they are used; no latching at note start.

Reset
REQ-026 While rst_n is low at a clock edge: state = IDLE, lvl = 0, cv = 0, active = 0, prescaler = 0, registered gate = 0.
REQ-027 A gate held high through reset release is seen as a rise on the first cycle after rst_n goes high.
REQ-028 Reset mid-note aborts the envelope; cv is 0 on the cycle after the reset edge.

Structure
REQ-029 State encoding constants and the default WIDTH/PRESCALE values live in the shared synth package/header used by the other synth modules.
REQ-030 Prescaler is one sub-module, tick_gen (parameter PRESCALE; ports clk, rst_n, tick); everything else is in adsr_env.

Verification (WIDTH=8, PRESCALE=1 unless stated)
REQ-031 attack=255, gate rises from IDLE -> cv reaches 255 on the 256th tick after the rise, state DECAY the next cycle.
REQ-032 attack=255, decay=255, sustain=128, gate held -> lvl settles at 0x8000, state SUSTAIN; sustain changed to 64 -> cv = 64 the next cycle.
REQ-033 From SUSTAIN at cv=128, gate falls, release=0 -> cv falls 1 LSB every 256 ticks; state IDLE and active=0 one tick after lvl=0.
REQ-034 Gate re-rises during RELEASE at cv=40 -> ATTACK starts from cv=40, no dip to 0.
REQ-035 PRESCALE=4: gate rise coincides with a tick -> state ATTACK, lvl unchanged that cycle; first increment on the next tick, 4 clocks later.
REQ-036 rst_n low for one cycle mid-ATTACK at cv=100 with gate high -> cv=0, state IDLE; ATTACK restarts from 0 on the first cycle after release of reset.

Source files
------------

// File: rtl/adsr_env_pkg.sv
// adsr_env_pkg: shared definitions for the ADSR envelope generator.
//   ADSR_WIDTH    - default width of rate codes, sustain level and cv
//   ADSR_PRESCALE - default clocks per envelope tick
//   adsr_state_t  - envelope state encoding
package adsr_env_pkg;

  localparam int ADSR_WIDTH    = 8;
  localparam int ADSR_PRESCALE = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_t;

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle envelope tick.
//   clk   - clock
//   rst_n - synchronous active-low reset (count returns to 0)
//   tick  - high for one cycle when the count is PRESCALE-1; count then wraps
//           to 0. PRESCALE=1 ticks every cycle.
module tick_gen
  import adsr_env_pkg::*;
#(
  parameter int PRESCALE = ADSR_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [15:0] cnt;

  assign tick = (cnt == 16'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/adsr_env.sv
// adsr_env: attack/decay/sustain/release envelope generator.
//   clk     - clock; rst_n - synchronous active-low reset
//   gate    - note gate, high while the key is held
//   attack  - attack rate code (larger = faster)
//   decay   - decay rate code (larger = faster)
//   sustain - sustain level
//   rel     - release rate code (larger = faster); named rel because
//             "release" is a reserved word
//   cv      - envelope level (upper half of the level register)
//   active  - high whenever the envelope is not idle
//
// state   | meaning
// IDLE    | no note, level held at 0
// ATTACK  | level rising by attack+1 per tick up to full scale
// DECAY   | level falling by decay+1 per tick down to the sustain target
// SUSTAIN | level tracks the live sustain input every cycle
// RELEASE | level falling by rel+1 per tick down to 0, then IDLE
module adsr_env
  import adsr_env_pkg::*;
#(
  parameter int WIDTH    = ADSR_WIDTH,
  parameter int PRESCALE = ADSR_PRESCALE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gate,
  input  logic [WIDTH-1:0] attack,
  input  logic [WIDTH-1:0] decay,
  input  logic [WIDTH-1:0] sustain,
  input  logic [WIDTH-1:0] rel,
  output logic [WIDTH-1:0] cv,
  output logic             active
);

  localparam int LW = 2 * WIDTH;

  adsr_state_t   state, state_n;
  logic [LW-1:0] lvl, lvl_n;
  logic          gate_q;
  logic          tick;
  logic          rise, fall;
  logic [LW-1:0] target, step_a, step_d, step_r;
  logic [LW:0]   sum_a, diff_d;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign rise   = gate & ~gate_q;
  assign fall   = ~gate & gate_q;
  assign target = {sustain, {WIDTH{1'b0}}};
  assign step_a = LW'(attack) + LW'(1);
  assign step_d = LW'(decay) + LW'(1);
  assign step_r = LW'(rel) + LW'(1);
  // One extra bit catches attack overflow and decay borrow.
  assign sum_a  = {1'b0, lvl} + {1'b0, step_a};
  assign diff_d = {1'b0, lvl} - {1'b0, step_d};

  always_comb begin
    state_n = state;
    lvl_n   = lvl;
    // Gate edges take priority over a coincident tick; level is kept.
    if (rise && state != ATTACK) begin
      state_n = ATTACK;
    end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
      state_n = RELEASE;
    end else begin
      case (state)
        IDLE: lvl_n = '0;
        ATTACK: if (tick) begin
          if (sum_a[LW] || (&sum_a[LW-1:0])) begin
            lvl_n   = '1;
            state_n = DECAY;
          end else begin
            lvl_n = sum_a[LW-1:0];
          end
        end
        DECAY: if (tick) begin
          if (lvl <= target || diff_d[LW] || diff_d[LW-1:0] <= target) begin
            lvl_n   = target;
            state_n = SUSTAIN;
          end else begin
            lvl_n = diff_d[LW-1:0];
          end
        end
        SUSTAIN: lvl_n = target;
        RELEASE: if (tick) begin
          if (lvl == '0)         state_n = IDLE;
          else if (lvl <= step_r) lvl_n  = '0;
          else                    lvl_n  = lvl - step_r;
        end
        default: begin
          state_n = IDLE;
          lvl_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      lvl    <= '0;
      gate_q <= 1'b0;
    end else begin
      state  <= state_n;
      lvl    <= lvl_n;
      gate_q <= gate;
    end
  end

  assign cv     = lvl[LW-1:WIDTH];
  assign active = (state != IDLE);

endmodule

// File: tb/tb_adsr_env.sv
// tb_adsr_env: directed bench for adsr_env. dut runs with PRESCALE=1,
// dut4 with PRESCALE=4 to check gate-edge/tick coincidence and tick spacing.
module tb_adsr_env;
  import adsr_env_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       gate, gate4;
  logic [7:0] attack, decay, sustain, rel;
  logic [7:0] cv, cv4;
  logic       active, active4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adsr_env #(.WIDTH(8), .PRESCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .gate(gate),
    .attack(attack), .decay(decay), .sustain(sustain), .rel(rel),
    .cv(cv), .active(active)
  );

  adsr_env #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .gate(gate4),
    .attack(attack), .decay(decay), .sustain(sustain), .rel(rel),
    .cv(cv4), .active(active4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; gate = 1'b0; gate4 = 1'b0;
    attack = 8'd255; decay = 8'd255; sustain = 8'd128; rel = 8'd0;
    repeat (3) step();
    check("rst_cv",     32'(cv),        32'h0);
    check("rst_active", 32'(active),    32'h0);
    check("rst_state",  32'(dut.state), 32'(IDLE));
    check("rst_lvl4",   32'(dut4.lvl),  32'h0);

    // Prescale-4: wait for a tick, raise gate4 on it.
    rst_n = 1'b1;
    for (int i = 0; i < 8 && !dut4.u_tick.tick; i++) step();
    check("p4_tick_found", 32'(dut4.u_tick.tick), 32'h1);
    gate4 = 1'b1;
    step();
    check("p4_edge_state", 32'(dut4.state), 32'(ATTACK));
    check("p4_edge_lvl",   32'(dut4.lvl),   32'h0);
    check("idle_lvl",      32'(dut.lvl),    32'h0);
    check("idle_state",    32'(dut.state),  32'(IDLE));
    repeat (3) step();
    check("p4_before_tick", 32'(dut4.lvl), 32'h0);
    step();
    check("p4_first_inc",   32'(dut4.lvl), 32'h100);

    // Attack from idle, rise coincides with a tick.
    gate = 1'b1;
    step();
    check("atk_edge_state", 32'(dut.state), 32'(ATTACK));
    check("atk_edge_lvl",   32'(dut.lvl),   32'h0);
    check("atk_active",     32'(active),    32'h1);
    repeat (255) step();
    check("atk_cv255",      32'(cv),        32'd255);
    check("atk_lvl_ff00",   32'(dut.lvl),   32'hFF00);
    check("atk_still",      32'(dut.state), 32'(ATTACK));
    step();
    check("atk_sat_lvl",    32'(dut.lvl),   32'hFFFF);
    check("atk_to_decay",   32'(dut.state), 32'(DECAY));

    // Decay to sustain 128.
    repeat (127) step();
    check("dec_lvl",        32'(dut.lvl),   32'h80FF);
    check("dec_state",      32'(dut.state), 32'(DECAY));
    step();
    check("dec_to_target",  32'(dut.lvl),   32'h8000);
    check("dec_to_sus",     32'(dut.state), 32'(SUSTAIN));
    sustain = 8'd64;
    step();
    check("sus_follow64",   32'(cv),        32'd64);
    sustain = 8'd128;
    step();
    check("sus_follow128",  32'(cv),        32'd128);

    // Slow release to idle.
    gate = 1'b0;
    step();
    check("rel_edge_state", 32'(dut.state), 32'(RELEASE));
    check("rel_edge_lvl",   32'(dut.lvl),   32'h8000);
    repeat (256) step();
    check("rel_cv127",      32'(cv),        32'd127);
    check("rel_lvl",        32'(dut.lvl),   32'h7F00);
    repeat (32512) step();
    check("rel_zero_lvl",   32'(dut.lvl),   32'h0);
    check("rel_zero_state", 32'(dut.state), 32'(RELEASE));
    check("rel_zero_act",   32'(active),    32'h1);
    step();
    check("rel_idle",       32'(dut.state), 32'(IDLE));
    check("rel_idle_act",   32'(active),    32'h0);

    // Re-attack during release at cv=40.
    gate = 1'b1;
    step();
    repeat (50) step();
    check("ra_cv50",        32'(cv),        32'd50);
    gate = 1'b0; rel = 8'd255;
    step();
    check("ra_rel_state",   32'(dut.state), 32'(RELEASE));
    repeat (10) step();
    check("ra_cv40",        32'(cv),        32'd40);
    gate = 1'b1;
    step();
    check("ra_attack",      32'(dut.state), 32'(ATTACK));
    check("ra_no_dip",      32'(dut.lvl),   32'h2800);
    step();
    check("ra_cv41",        32'(cv),        32'd41);

    // Reset mid-attack with gate held.
    repeat (59) step();
    check("mr_cv100",       32'(cv),        32'd100);
    rst_n = 1'b0;
    step();
    check("mr_cv0",         32'(cv),        32'h0);
    check("mr_idle",        32'(dut.state), 32'(IDLE));
    check("mr_active",      32'(active),    32'h0);
    rst_n = 1'b1;
    step();
    check("mr_restart",     32'(dut.state), 32'(ATTACK));
    check("mr_restart_lvl", 32'(dut.lvl),   32'h0);
    step();
    check("mr_first_inc",   32'(dut.lvl),   32'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
